// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache controller:
// FSM encoding and the line/offset address field positions.
package dcache_pkg;
   localparam int LINE_WORDS = 4;
   localparam int WORD_W     = 32;
   localparam int LINE_W     = LINE_WORDS * WORD_W;
   localparam int OFF_LO     = 2;   // word offset field [3:2]
   localparam int OFF_HI     = 3;
   localparam int LADDR_LO   = 4;   // line address field [31:4]

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FILL    = 3'd1,
      INSTALL = 3'd2,
      RESPOND = 3'd3,
      WRITE   = 3'd4
   } state_t;
endpackage

// File: rtl/dcache_line_buf.sv
// Word buffer that assembles a line from serial memory beats and
// returns the requested word once the line is complete.
module dcache_line_buf #(
   parameter int WORDS  = 4,
   parameter int DATA_W = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wr_en,
   input  logic [$clog2(WORDS)-1:0]        wr_idx,
   input  logic [DATA_W-1:0]               wr_data,
   input  logic [$clog2(WORDS)-1:0]        rd_idx,
   output logic [DATA_W-1:0]               rd_data,
   output logic [WORDS-1:0][DATA_W-1:0]    line
);

   always_ff @(posedge clk) begin
      if (reset)      line         <= '0;
      else if (wr_en) line[wr_idx] <= wr_data;
   end

   assign rd_data = line[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped D-cache sequencer: single-cycle read hits, word-serial line
// fill on read miss, write-through/no-write-allocate stores, perf counters.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = WORD_W,
   parameter int WORDS  = LINE_WORDS,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cpu_read,
   input  logic                    cpu_write,
   input  logic [ADDR_W-1:0]       cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    cpu_ready,
   output logic [ADDR_W-1:0]       cache_addr,
   output logic                    cache_read,
   input  logic                    cache_hit,
   input  logic [DATA_W-1:0]       cache_rdata,
   output logic                    cache_fill,
   output logic [WORDS*DATA_W-1:0] cache_line,
   output logic                    cache_wr_word,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic                    mem_ack,
   input  logic [DATA_W-1:0]       mem_rdata,
   output logic [CNT_W-1:0]        hit_cnt,
   output logic [CNT_W-1:0]        miss_cnt
);

   localparam int BW = $clog2(WORDS);

   state_t                       state, state_d;
   logic [BW-1:0]                beat;
   logic [ADDR_W-1:0]            addr_q;
   logic                         hit_q;
   logic                         accept, fill_wr, hit_inc, miss_inc;
   logic [DATA_W-1:0]            buf_rdata;
   logic [WORDS-1:0][DATA_W-1:0] buf_line;

   dcache_line_buf #(.WORDS(WORDS), .DATA_W(DATA_W)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (fill_wr),
      .wr_idx  (beat),
      .wr_data (mem_rdata),
      .rd_idx  (addr_q[OFF_LO+BW-1:OFF_LO]),
      .rd_data (buf_rdata),
      .line    (buf_line)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         beat     <= '0;
         addr_q   <= '0;
         hit_q    <= 1'b0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            addr_q <= cpu_addr;
            hit_q  <= cache_hit;
            beat   <= '0;
         end else if (fill_wr) begin
            beat <= beat + 1'b1;
         end
         if (hit_inc  && hit_cnt  != '1) hit_cnt  <= hit_cnt  + 1'b1;
         if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
   end

   always_comb begin
      state_d       = state;
      accept        = 1'b0;
      fill_wr       = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;
      cpu_ready     = 1'b0;
      cpu_rdata     = '0;
      cache_addr    = addr_q;
      cache_read    = 1'b0;
      cache_fill    = 1'b0;
      cache_line    = '0;
      cache_wr_word = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      // Outputs are held at zero for the whole reset cycle.
      if (reset) begin
         cache_addr = '0;
      end else begin
         case (state)
            IDLE: begin
               cache_addr = cpu_addr;
               cache_read = cpu_read | cpu_write;
               if (cpu_write) begin
                  accept  = 1'b1;
                  state_d = WRITE;
               end else if (cpu_read) begin
                  if (cache_hit) begin
                     cpu_ready = 1'b1;
                     cpu_rdata = cache_rdata;
                     hit_inc   = 1'b1;
                  end else begin
                     accept   = 1'b1;
                     miss_inc = 1'b1;
                     state_d  = FILL;
                  end
               end
            end
            FILL: begin
               mem_req  = 1'b1;
               mem_addr = {addr_q[ADDR_W-1:OFF_LO+BW], beat, 2'b00};
               fill_wr  = mem_ack;
               if (mem_ack && beat == BW'(WORDS-1)) state_d = INSTALL;
            end
            INSTALL: begin
               cache_fill = 1'b1;
               cache_line = buf_line;
               state_d    = RESPOND;
            end
            RESPOND: begin
               cpu_ready = 1'b1;
               cpu_rdata = buf_rdata;
               state_d   = IDLE;
            end
            WRITE: begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = addr_q;
               mem_wdata = cpu_wdata;
               if (mem_ack) begin
                  cpu_ready     = 1'b1;
                  cache_wr_word = hit_q;
                  state_d       = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller; counter saturation is exercised on a
// second instance with narrow counters to keep the run short.
module tb_dcache_controller;
   import dcache_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_read, cpu_write;
   logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
   logic          cpu_ready;
   logic [31:0]   cache_addr;
   logic          cache_read, cache_hit;
   logic [31:0]   cache_rdata;
   logic          cache_fill;
   logic [127:0]  cache_line;
   logic          cache_wr_word;
   logic          mem_req, mem_we, mem_ack;
   logic [31:0]   mem_addr, mem_wdata, mem_rdata;
   logic [15:0]   hit_cnt, miss_cnt;

   logic          s_read, s_write, s_ready, s_cread, s_hit, s_fill, s_wr_word;
   logic          s_req, s_we, s_ack;
   logic [31:0]   s_addr, s_wdata, s_rdata, s_caddr, s_crdata, s_maddr, s_mwdata, s_mrdata;
   logic [127:0]  s_line;
   logic [3:0]    s_hit_cnt, s_miss_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dcache_controller dut (
      .clk(clk), .reset(reset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .cache_addr(cache_addr), .cache_read(cache_read), .cache_hit(cache_hit),
      .cache_rdata(cache_rdata), .cache_fill(cache_fill), .cache_line(cache_line),
      .cache_wr_word(cache_wr_word), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   dcache_controller #(.CNT_W(4)) u_sat (
      .clk(clk), .reset(reset),
      .cpu_read(s_read), .cpu_write(s_write), .cpu_addr(s_addr),
      .cpu_wdata(s_wdata), .cpu_rdata(s_rdata), .cpu_ready(s_ready),
      .cache_addr(s_caddr), .cache_read(s_cread), .cache_hit(s_hit),
      .cache_rdata(s_crdata), .cache_fill(s_fill), .cache_line(s_line),
      .cache_wr_word(s_wr_word), .mem_req(s_req), .mem_we(s_we),
      .mem_addr(s_maddr), .mem_wdata(s_mwdata), .mem_ack(s_ack),
      .mem_rdata(s_mrdata), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Store through the main instance: 2 wait cycles, ack on the third.
   task automatic do_write(input logic hit, input string tag);
      cpu_write = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFE0001; cache_hit = hit;
      #1 chk({tag, "_req_ready"}, cpu_ready, 1'b0);
      chk({tag, "_req_cread"}, cache_read, 1'b1);
      cyc();
      cache_hit = ~hit;   // latched hit must be used, not the live one
      for (int w = 0; w < 2; w++) begin
         #1 chk({tag, "_mreq"}, mem_req, 1'b1);
         chk({tag, "_mwe"}, mem_we, 1'b1);
         chk({tag, "_maddr"}, mem_addr, 32'h20);
         chk({tag, "_mwdata"}, mem_wdata, 32'hCAFE0001);
         chk({tag, "_wait_ready"}, cpu_ready, 1'b0);
         cyc();
      end
      mem_ack = 1'b1;
      #1 chk({tag, "_ack_ready"}, cpu_ready, 1'b1);
      chk({tag, "_wr_word"}, cache_wr_word, hit);
      chk({tag, "_nofill"}, cache_fill, 1'b0);
      cyc();
      mem_ack = 1'b0; cpu_write = 1'b0; cache_hit = 1'b0;
      #1 chk({tag, "_done_mreq"}, mem_req, 1'b0);
      chk({tag, "_done_wr_word"}, cache_wr_word, 1'b0);
   endtask

   // Read miss on the saturation instance with a 0-wait memory.
   task automatic sat_miss();
      s_read = 1'b1; s_addr = 32'h400; s_hit = 1'b0;
      cyc();
      s_ack = 1'b1; s_mrdata = 32'h77;
      repeat (4) cyc();
      s_ack = 1'b0;
      cyc();
      cyc();
      s_read = 1'b0;
   endtask

   logic [31:0] fill_data [4];

   initial begin
      reset = 1'b1;
      cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
      cache_hit = 0; cache_rdata = 0; mem_ack = 0; mem_rdata = 0;
      s_read = 0; s_write = 0; s_addr = 0; s_wdata = 0;
      s_hit = 0; s_crdata = 0; s_ack = 0; s_mrdata = 0;
      cyc(); cyc();
      #1 chk("rst_ready", cpu_ready, 1'b0);
      chk("rst_mreq", mem_req, 1'b0);
      chk("rst_fill", cache_fill, 1'b0);
      chk("rst_caddr", cache_addr, 32'h0);
      chk("rst_hit", hit_cnt, 16'h0);
      chk("rst_miss", miss_cnt, 16'h0);
      chk("rst_state", dut.state, IDLE);
      reset = 1'b0;

      // Read hit
      cyc();
      cpu_read = 1'b1; cpu_addr = 32'h40; cache_hit = 1'b1; cache_rdata = 32'hDEADBEEF;
      #1 chk("hit_ready", cpu_ready, 1'b1);
      chk("hit_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("hit_caddr", cache_addr, 32'h40);
      chk("hit_cread", cache_read, 1'b1);
      chk("hit_mreq", mem_req, 1'b0);
      cyc();
      cpu_read = 1'b0; cache_hit = 1'b0; cache_rdata = 0;
      #1 chk("hit_cnt1", hit_cnt, 16'd1);
      chk("hit_miss0", miss_cnt, 16'd0);

      // Read miss, 2 wait cycles per beat
      fill_data[0] = 32'h11; fill_data[1] = 32'h22; fill_data[2] = 32'h33; fill_data[3] = 32'h44;
      cpu_read = 1'b1; cpu_addr = 32'h104;
      #1 chk("miss_req_ready", cpu_ready, 1'b0);
      cyc();
      cpu_addr = 32'hFFF0;   // ignored after acceptance
      #1 chk("miss_cnt1", miss_cnt, 16'd1);
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < 3; w++) begin
            if (w == 2) begin mem_ack = 1'b1; mem_rdata = fill_data[b]; end
            #1 chk("miss_mreq", mem_req, 1'b1);
            chk("miss_mwe", mem_we, 1'b0);
            chk("miss_maddr", mem_addr, 32'h100 + 32'(4*b));
            chk("miss_ready", cpu_ready, 1'b0);
            chk("miss_nofill", cache_fill, 1'b0);
            cyc();
         end
         mem_ack = 1'b0;
      end
      #1 chk("inst_fill", cache_fill, 1'b1);
      chk("inst_line", cache_line, 128'h00000044_00000033_00000022_00000011);
      chk("inst_caddr", cache_addr, 32'h104);
      chk("inst_ready", cpu_ready, 1'b0);
      chk("inst_mreq", mem_req, 1'b0);
      cyc();
      #1 chk("resp_ready", cpu_ready, 1'b1);
      chk("resp_rdata", cpu_rdata, 32'h22);
      chk("resp_fill", cache_fill, 1'b0);
      cyc();
      cpu_read = 1'b0;
      #1 chk("post_miss_ready", cpu_ready, 1'b0);
      chk("post_miss_cnt", miss_cnt, 16'd1);
      chk("post_miss_hit", hit_cnt, 16'd1);

      // Write-through, hit then miss
      do_write(1'b1, "wr_hit");
      do_write(1'b0, "wr_miss");
      chk("wr_hitcnt", hit_cnt, 16'd1);
      chk("wr_misscnt", miss_cnt, 16'd1);

      // Stray ack while idle is ignored
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      #1 chk("stray_state", dut.state, IDLE);
      chk("stray_ready", cpu_ready, 1'b0);

      // Reset in the middle of a fill
      cpu_read = 1'b1; cpu_addr = 32'h200;
      cyc();
      mem_ack = 1'b1; mem_rdata = 32'hA1;
      cyc();
      mem_rdata = 32'hA2;
      cyc();
      mem_ack = 1'b0; cpu_read = 1'b0; reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1 chk("rfill_state", dut.state, IDLE);
      chk("rfill_mreq", mem_req, 1'b0);
      chk("rfill_hit", hit_cnt, 16'd0);
      chk("rfill_miss", miss_cnt, 16'd0);
      chk("rfill_fill", cache_fill, 1'b0);
      cyc();
      #1 chk("rfill_fill2", cache_fill, 1'b0);
      cpu_read = 1'b1; cpu_addr = 32'h304;
      cyc();
      #1 chk("restart_state", dut.state, FILL);
      chk("restart_miss", miss_cnt, 16'd1);
      for (int b = 0; b < 4; b++) begin
         mem_ack = 1'b1; mem_rdata = 32'hB0 + 32'(b);
         #1 chk("restart_maddr", mem_addr, 32'h300 + 32'(4*b));
         cyc();
      end
      mem_ack = 1'b0;
      #1 chk("restart_line", cache_line, 128'h000000B3_000000B2_000000B1_000000B0);
      cyc();
      #1 chk("restart_ready", cpu_ready, 1'b1);
      chk("restart_rdata", cpu_rdata, 32'hB1);
      cyc();
      cpu_read = 1'b0;

      // Read and write together: write wins
      cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'h5555AAAA;
      cache_hit = 1'b1; cache_rdata = 32'h12345678;
      #1 chk("rw_ready", cpu_ready, 1'b0);
      cyc();
      cache_hit = 1'b0;
      #1 chk("rw_mwe", mem_we, 1'b1);
      chk("rw_maddr", mem_addr, 32'h8);
      chk("rw_mwdata", mem_wdata, 32'h5555AAAA);
      mem_ack = 1'b1;
      #1 chk("rw_ack_ready", cpu_ready, 1'b1);
      chk("rw_wr_word", cache_wr_word, 1'b1);
      cyc();
      mem_ack = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
      #1 chk("rw_hitcnt", hit_cnt, 16'd0);
      chk("rw_misscnt", miss_cnt, 16'd1);
      chk("rw_mreq", mem_req, 1'b0);

      // Counter saturation on the 4-bit instance
      repeat (14) sat_miss();
      #1 chk("sat_miss14", s_miss_cnt, 4'hE);
      sat_miss();
      #1 chk("sat_miss15", s_miss_cnt, 4'hF);
      sat_miss();
      #1 chk("sat_miss16", s_miss_cnt, 4'hF);
      chk("sat_hit0", s_hit_cnt, 4'h0);
      s_read = 1'b1; s_hit = 1'b1; s_crdata = 32'h99;
      repeat (17) cyc();
      s_read = 1'b0; s_hit = 1'b0;
      #1 chk("sat_hit17", s_hit_cnt, 4'hF);
      chk("sat_miss_keep", s_miss_cnt, 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
